// File: rtl/sal_cmd_sched.sv
// Inter-bank DDR2 command scheduler: round-robin pick of one ACT/RD/WR/PRE per cycle
// while honouring tRRD, tCCD, tWTR and tRTW between granted commands.
module sal_cmd_sched #(
    parameter int NUM_BANKS = 4,
    parameter int TW = 4,
    localparam int BW = $clog2(NUM_BANKS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TW-1:0]          t_rrd,
    input  logic [TW-1:0]          t_ccd,
    input  logic [TW-1:0]          t_wtr,
    input  logic [TW-1:0]          t_rtw,
    input  logic [NUM_BANKS-1:0]   req_valid,
    input  logic [2*NUM_BANKS-1:0] req_cmd,
    output logic [NUM_BANKS-1:0]   req_grant,
    output logic                   cmd_valid,
    output logic [1:0]             cmd_type,
    output logic [BW-1:0]          cmd_bank
);

    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_RD  = 2'b01,
        CMD_WR  = 2'b10,
        CMD_PRE = 2'b11
    } cmd_e;

    logic [TW-1:0]        rrd_cnt_r, ccd_cnt_r, wtr_cnt_r, rtw_cnt_r;
    logic [BW-1:0]        rr_ptr_r;
    logic [NUM_BANKS-1:0] elig_s;
    logic [NUM_BANKS-1:0] grant_s;
    logic [BW-1:0]        idx_s;
    logic [BW-1:0]        gidx_s;
    logic                 found_s;
    logic [1:0]           gcmd_s;

    // A constraint of 0 or 1 cycles never blocks the next cycle, so both load 0.
    function automatic logic [TW-1:0] sat_load(input logic [TW-1:0] t);
        if (t > TW'(1)) begin
            sat_load = t - TW'(1);
        end else begin
            sat_load = {TW{1'b0}};
        end
    endfunction

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] c);
        if (c != {TW{1'b0}}) begin
            sat_dec = c - TW'(1);
        end else begin
            sat_dec = {TW{1'b0}};
        end
    endfunction

    // Per-bank eligibility from the requested command and the live counters.
    always_comb begin
        elig_s = {NUM_BANKS{1'b0}};
        for (int i = 0; i < NUM_BANKS; i++) begin
            case (req_cmd[2*i +: 2])
                CMD_ACT: elig_s[i] = (rrd_cnt_r == {TW{1'b0}});
                CMD_RD:  elig_s[i] = (ccd_cnt_r == {TW{1'b0}}) && (wtr_cnt_r == {TW{1'b0}});
                CMD_WR:  elig_s[i] = (ccd_cnt_r == {TW{1'b0}}) && (rtw_cnt_r == {TW{1'b0}});
                CMD_PRE: elig_s[i] = 1'b1;
                default: elig_s[i] = 1'b0;
            endcase
            elig_s[i] = elig_s[i] & req_valid[i] & ~rst;
        end
    end

    // Round-robin search starting at rr_ptr; index arithmetic wraps at NUM_BANKS.
    always_comb begin
        found_s = 1'b0;
        gidx_s  = {BW{1'b0}};
        idx_s   = {BW{1'b0}};
        grant_s = {NUM_BANKS{1'b0}};
        for (int k = 0; k < NUM_BANKS; k++) begin
            idx_s = rr_ptr_r + BW'(k);
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                gidx_s  = idx_s;
            end else begin
                gidx_s  = gidx_s;
            end
        end
        grant_s[gidx_s] = found_s;
        gcmd_s = req_cmd[{gidx_s, 1'b0} +: 2];
    end

    assign req_grant = grant_s;

    // Timing counters: decrement toward 0, reload from parameters on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrd_cnt_r <= {TW{1'b0}};
            ccd_cnt_r <= {TW{1'b0}};
            wtr_cnt_r <= {TW{1'b0}};
            rtw_cnt_r <= {TW{1'b0}};
        end else begin
            rrd_cnt_r <= sat_dec(rrd_cnt_r);
            ccd_cnt_r <= sat_dec(ccd_cnt_r);
            wtr_cnt_r <= sat_dec(wtr_cnt_r);
            rtw_cnt_r <= sat_dec(rtw_cnt_r);
            if (found_s) begin
                case (gcmd_s)
                    CMD_ACT: rrd_cnt_r <= sat_load(t_rrd);
                    CMD_RD: begin
                        ccd_cnt_r <= sat_load(t_ccd);
                        rtw_cnt_r <= sat_load(t_rtw);
                    end
                    CMD_WR: begin
                        ccd_cnt_r <= sat_load(t_ccd);
                        wtr_cnt_r <= sat_load(t_wtr);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Bus output register and round-robin pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r  <= {BW{1'b0}};
            cmd_valid <= 1'b0;
            cmd_type  <= 2'b00;
            cmd_bank  <= {BW{1'b0}};
        end else begin
            cmd_valid <= found_s;
            if (found_s) begin
                rr_ptr_r <= gidx_s + BW'(1);
                cmd_type <= gcmd_s;
                cmd_bank <= gidx_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

endmodule

// File: doc/sal_cmd_sched.md
# sal_cmd_sched

Inter-bank command scheduler for the DDR2 controller. Sits between the per-bank controllers and the DRAM command bus. Each cycle it picks at most one ACT/RD/WR/PRE request from the bank controllers, using round-robin arbitration. It enforces the scheduler-level timing constraints tRRD, tCCD, tWTR and tRTW, which it takes from the configuration block's timing outputs.

## Interface
- NUM_BANKS, 4: number of bank-controller requesters (power of 2, 2..8)
- TW, 4: width of timing parameters and internal counters
- clk  input  1  controller clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- t_rrd  input  TW  min cycles ACT→ACT (any banks)
- t_ccd  input  TW  min cycles RD/WR→RD/WR
- t_wtr  input  TW  min cycles WR→RD
- t_rtw  input  TW  min cycles RD→WR
- req_valid  input  NUM_BANKS  per-bank request pending
- req_cmd  input  2*NUM_BANKS  per-bank command: 2'b00 ACT, 2'b01 RD, 2'b10 WR, 2'b11 PRE
- req_grant  output  NUM_BANKS  one-hot grant, combinational, same cycle as acceptance
- cmd_valid  output  1  registered: command issued on bus this cycle
- cmd_type  output  2  registered command code
- cmd_bank  output  log2(NUM_BANKS)  registered bank index

## Operation
- Handshake:
  - A bank asserts req_valid[i] with a stable req_cmd[i] and holds both until req_grant[i]=1.
  - The transfer happens in the cycle where req_valid[i]&req_grant[i]; the bank may change or drop the request in the next cycle.
  - A bank must not withdraw a request before it is granted.
- Eligibility per bank, evaluated on current counter values:
  - ACT: rrd_cnt==0
  - RD: ccd_cnt==0 && wtr_cnt==0
  - WR: ccd_cnt==0 && rtw_cnt==0
  - PRE: always eligible
- Arbitration:
  - Round-robin pointer rr_ptr (log2(NUM_BANKS) bits).
  - Grant the first eligible requesting bank, searching from rr_ptr upward with wrap-around.
  - At most one grant per cycle; req_grant is 0 when no bank is eligible.
  - On grant to bank g, rr_ptr ← (g+1) mod NUM_BANKS. Without a grant, rr_ptr holds.
- Counters: four down-counters of TW bits, saturating at 0, each decrementing by 1 per cycle when nonzero. On the grant edge:
  - ACT: rrd_cnt ← sat(t_rrd−1)
  - RD: ccd_cnt ← sat(t_ccd−1), rtw_cnt ← sat(t_rtw−1)
  - WR: ccd_cnt ← sat(t_ccd−1), wtr_cnt ← sat(t_wtr−1)
  - PRE: no counter load
  - sat(x)=0 when the parameter is 0 or 1. A load overrides the decrement in the same cycle.
- Output register: on the grant edge, cmd_valid←1, cmd_type←req_cmd[g], cmd_bank←g. Otherwise cmd_valid←0; cmd_type and cmd_bank hold their last value.
- Timing parameters are sampled only when a counter is loaded. A parameter change mid-countdown does not affect the running counter.
- Reset (synchronous, any cycle, including mid-countdown):
  - all counters 0, rr_ptr 0
  - cmd_valid 0, cmd_type 2'b00, cmd_bank 0
  - req_grant is forced to 0 while rst=1
  - Requests pending during reset are not granted and must be re-presented.

## Timing
- Grant-to-bus latency is 1 cycle: granted in cycle T, cmd_valid=1 in cycle T+1.
- With constraint value t, the earliest next dependent grant is cycle T+t (bus cycle T+t+1). Back-to-back grants occur when t≤1.
- Peak throughput is one command per cycle. A PRE, or a command with no active constraint, can follow any command on the next cycle.
- Arbitration and eligibility form a single combinational stage: req_valid/req_cmd → req_grant in the same cycle.

## Test plan
- Reset: hold rst for 3 cycles with all req_valid=1 → req_grant=0 throughout; the cycle after release, cmd_valid=0, cmd_bank=0; bank 0 is granted first.
- tRRD: t_rrd=4, banks 0 and 1 request ACT in cycle 0 → bank 0 granted at 0, bank 1 granted at 4; cmd_valid pulses at cycles 1 and 5.
- Turnaround: t_wtr=6, t_rtw=3, t_ccd=2:
  - WR to bank 2 granted at cycle 0, then RD from bank 3 pending → RD granted at 6.
  - Separately, RD granted at 0 with WR pending → WR granted at 3.
- Round-robin fairness: all 4 banks request PRE continuously → grants 0,1,2,3,0,1… one per cycle, cmd_bank follows one cycle later.
- Mixed eligibility: rrd_cnt nonzero, bank 0 requests ACT, bank 1 requests PRE → bank 1 granted immediately; bank 0 granted when rrd_cnt reaches 0, with no starvation.
- Mid-countdown reset: t_ccd=8, RD granted, rst asserted 2 cycles later → after release, ccd_cnt=0 and a RD is granted in the first post-reset cycle.
